psum_acc_buf: RTL and testbench

PSUM_ACC_BUF -- requirements
Module: psum_acc_buf

---
 rtl/psum_acc_if.sv | 27 ++
 rtl/psum_acc_buf.sv | 148 ++++++++++++++
 tb/tb_psum_acc_buf.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/psum_acc_if.sv
// Bundle of the psum_acc_buf control, partial-sum input and result streams.
// master = job/stream driver side, slave = psum_acc_buf.
interface psum_acc_if;
    logic        ctrl_valid;
    logic        ctrl_ready;
    logic        ctrl_finish;
    logic [7:0]  k_num_i;
    logic [15:0] grp_num_i;
    logic        bit_mode_i;
    logic        pe_valid;
    logic        pe_ready;
    logic [95:0] pe_psum;
    logic        psum_almost_valid;
    logic        psum_valid;
    logic        psum_ready;
    logic [95:0] psum_data;

    modport master (
        output ctrl_valid, k_num_i, grp_num_i, bit_mode_i, pe_valid, pe_psum, psum_ready,
        input  ctrl_ready, ctrl_finish, pe_ready, psum_almost_valid, psum_valid, psum_data
    );

    modport slave (
        input  ctrl_valid, k_num_i, grp_num_i, bit_mode_i, pe_valid, pe_psum, psum_ready,
        output ctrl_ready, ctrl_finish, pe_ready, psum_almost_valid, psum_valid, psum_data
    );
endinterface

// File: rtl/psum_acc_buf.sv
// Partial-sum accumulator with a one-word output buffer, six 16-bit lanes (or 12 8-bit sub-lanes).
// Define PSUM_ACC_SAT_EN to saturate each lane add instead of wrapping.
module psum_acc_buf (
    input logic        clk,
    input logic        rst_n,
    psum_acc_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q, state_d;
    logic [7:0]  k_num_q, k_num_d;
    logic [15:0] grp_num_q, grp_num_d;
    logic        bit_mode_q, bit_mode_d;
    logic [7:0]  cnt_k_q, cnt_k_d;
    logic [15:0] cnt_grp_q, cnt_grp_d;
    logic [95:0] acc_q, acc_d;
    logic [95:0] psum_data_q, psum_data_d;
    logic        psum_valid_q, psum_valid_d;
    logic        ctrl_finish_q, ctrl_finish_d;

    logic        pe_ready;
    logic        pe_fire;
    logic        out_fire;
    logic        is_final;
    logic [95:0] lane_sum;

    function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        s = a + b;
`ifdef PSUM_ACC_SAT_EN
        if (a[15] == b[15] && s[15] != a[15]) s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return s;
    endfunction

    function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        s = a + b;
`ifdef PSUM_ACC_SAT_EN
        if (a[7] == b[7] && s[7] != a[7]) s = a[7] ? 8'h80 : 8'h7F;
`endif
        return s;
    endfunction

    // Once the job's last word sits in the buffer, no further beats may enter.
    assign pe_ready = (state_q == RUN) &&
                      (!psum_valid_q || (bus.psum_ready && cnt_grp_q != grp_num_q));
    assign pe_fire  = bus.pe_valid && pe_ready;
    assign out_fire = psum_valid_q && bus.psum_ready;
    assign is_final = (cnt_k_q == k_num_q);

    assign bus.ctrl_ready        = (state_q == IDLE);
    assign bus.ctrl_finish       = ctrl_finish_q;
    assign bus.pe_ready          = pe_ready;
    assign bus.psum_almost_valid = pe_fire && is_final;
    assign bus.psum_valid        = psum_valid_q;
    assign bus.psum_data         = psum_data_q;

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < 6; l++) begin
            if (bit_mode_q) begin
                lane_sum[l*16+8 +: 8] = add8(acc_q[l*16+8 +: 8], bus.pe_psum[l*16+8 +: 8]);
                lane_sum[l*16   +: 8] = add8(acc_q[l*16   +: 8], bus.pe_psum[l*16   +: 8]);
            end else begin
                lane_sum[l*16 +: 16] = add16(acc_q[l*16 +: 16], bus.pe_psum[l*16 +: 16]);
            end
        end
    end

    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        k_num_d       = k_num_q;
        grp_num_d     = grp_num_q;
        bit_mode_d    = bit_mode_q;
        cnt_k_d       = cnt_k_q;
        cnt_grp_d     = cnt_grp_q;
        acc_d         = acc_q;
        psum_data_d   = psum_data_q;
        psum_valid_d  = psum_valid_q;
        ctrl_finish_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.ctrl_valid) begin
                    k_num_d    = bus.k_num_i;
                    grp_num_d  = bus.grp_num_i;
                    bit_mode_d = bus.bit_mode_i;
                    cnt_k_d    = '0;
                    cnt_grp_d  = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (out_fire) begin
                    psum_valid_d = 1'b0;
                    cnt_grp_d    = cnt_grp_q + 16'd1;
                    if (cnt_grp_q == grp_num_q) begin
                        ctrl_finish_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
                // A final beat in the same cycle as a handshake refills the buffer.
                if (pe_fire) begin
                    acc_d = (cnt_k_q == 8'd0) ? bus.pe_psum : lane_sum;
                    if (is_final) begin
                        psum_data_d  = acc_d;
                        psum_valid_d = 1'b1;
                        cnt_k_d      = '0;
                    end else begin
                        cnt_k_d = cnt_k_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            k_num_q       <= '0;
            grp_num_q     <= '0;
            bit_mode_q    <= 1'b0;
            cnt_k_q       <= '0;
            cnt_grp_q     <= '0;
            acc_q         <= '0;
            psum_data_q   <= '0;
            psum_valid_q  <= 1'b0;
            ctrl_finish_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_num_q       <= k_num_d;
            grp_num_q     <= grp_num_d;
            bit_mode_q    <= bit_mode_d;
            cnt_k_q       <= cnt_k_d;
            cnt_grp_q     <= cnt_grp_d;
            acc_q         <= acc_d;
            psum_data_q   <= psum_data_d;
            psum_valid_q  <= psum_valid_d;
            ctrl_finish_q <= ctrl_finish_d;
        end
    end

endmodule

// File: tb/tb_psum_acc_buf.sv
// Directed self-checking bench for psum_acc_buf; expected sums follow PSUM_ACC_SAT_EN.
module tb_psum_acc_buf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    psum_acc_if bus ();

    psum_acc_buf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] k, input logic [15:0] grp, input logic mode);
        bus.k_num_i    = k;
        bus.grp_num_i  = grp;
        bus.bit_mode_i = mode;
        bus.ctrl_valid = 1'b1;
        @(negedge clk);
        check("start_ctrl_ready_idle", bus.ctrl_ready, 1'b1);
        step();
        bus.ctrl_valid = 1'b0;
        @(negedge clk);
        check("start_ctrl_ready_run", bus.ctrl_ready, 1'b0);
        step();
    endtask

    task automatic beat(input string tag, input logic [95:0] d, input logic exp_almost);
        int n;
        bus.pe_valid = 1'b1;
        bus.pe_psum  = d;
        n = 0;
        @(negedge clk);
        while (!bus.pe_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_pe_ready"}, bus.pe_ready, 1'b1);
        check({tag, "_almost"}, bus.psum_almost_valid, exp_almost);
        step();
        bus.pe_valid = 1'b0;
    endtask

    task automatic expect_last_word(input string tag, input logic [95:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.psum_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, bus.psum_valid, 1'b1);
        check({tag, "_data"}, bus.psum_data, exp);
        check({tag, "_pe_blocked"}, bus.pe_ready, 1'b0);
        step();
        check({tag, "_finish"}, bus.ctrl_finish, 1'b1);
        check({tag, "_idle"}, bus.ctrl_ready, 1'b1);
        check({tag, "_valid_clr"}, bus.psum_valid, 1'b0);
        step();
        check({tag, "_finish_pulse"}, bus.ctrl_finish, 1'b0);
    endtask

    logic [95:0] w [5];
    logic [95:0] exp28, exp29;

    initial begin
        bus.ctrl_valid = 1'b0;
        bus.k_num_i    = '0;
        bus.grp_num_i  = '0;
        bus.bit_mode_i = 1'b0;
        bus.pe_valid   = 1'b1;
        bus.pe_psum    = 96'h1;
        bus.psum_ready = 1'b1;

        // Reset state, with a beat offered throughout.
        #22;
        check("rst_ctrl_ready", bus.ctrl_ready, 1'b1);
        check("rst_finish", bus.ctrl_finish, 1'b0);
        check("rst_psum_valid", bus.psum_valid, 1'b0);
        check("rst_psum_data", bus.psum_data, 96'h0);
        check("rst_pe_ready", bus.pe_ready, 1'b0);
        check("rst_almost", bus.psum_almost_valid, 1'b0);
        bus.pe_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_pe_ready", bus.pe_ready, 1'b0);

        // Three partials into lane0.
        start_job(8'd2, 16'd0, 1'b0);
        beat("k2_b0", 96'd10, 1'b0);
        beat("k2_b1", 96'd20, 1'b0);
        beat("k2_b2", 96'd30, 1'b1);
        expect_last_word("k2_word", 96'd60);

        // 16-bit lanes: positive/negative overflow and an in-range negative sum.
`ifdef PSUM_ACC_SAT_EN
        exp28 = {16'h2345, 32'h0, 16'h8000, 16'hFFF4, 16'h7FFF};
        exp29 = {64'h0, 16'h8000, 16'h7F02};
`else
        exp28 = {16'h2345, 32'h0, 16'h0000, 16'hFFF4, 16'h9C40};
        exp29 = {64'h0, 16'h7F00, 16'h8002};
`endif
        start_job(8'd1, 16'd0, 1'b0);
        beat("sat16_b0", {16'h1234, 32'h0, 16'h8000, 16'hFFFB, 16'h7530}, 1'b0);
        beat("sat16_b1", {16'h1111, 32'h0, 16'h8000, 16'hFFF9, 16'h2710}, 1'b1);
        expect_last_word("sat16_word", exp28);

        // 8-bit sub-lanes: no carry between halves.
        start_job(8'd1, 16'd0, 1'b1);
        beat("sub8_b0", {64'h0, 16'h80FF, 16'h7F01}, 1'b0);
        beat("sub8_b1", {64'h0, 16'hFF01, 16'h0101}, 1'b1);
        expect_last_word("sub8_word", exp29);

        // One word per beat with output back-pressure.
        w[0] = 96'h000A_0000_0000_0000_0000_1111;
        w[1] = 96'h000B_0000_0000_0000_0000_2222;
        w[2] = 96'h000C_0000_0000_0000_0000_3333;
        w[3] = 96'h000D_0000_0000_0000_0000_4444;
        w[4] = 96'hDEAD_0000_0000_0000_0000_BEEF;
        start_job(8'd0, 16'd3, 1'b0);
        bus.psum_ready = 1'b0;
        bus.pe_valid   = 1'b1;
        bus.pe_psum    = w[0];
        @(negedge clk);
        check("bp_first_almost", bus.psum_almost_valid, 1'b1);
        step();
        bus.pe_psum = w[1];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_pe_ready", bus.pe_ready, 1'b0);
            check("bp_hold_valid", bus.psum_valid, 1'b1);
            check("bp_hold_data", bus.psum_data, w[0]);
            step();
        end
        bus.psum_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("bp_stream_pe_ready", bus.pe_ready, 1'b1);
            check("bp_stream_almost", bus.psum_almost_valid, 1'b1);
            check("bp_stream_data", bus.psum_data, w[i-1]);
            step();
            bus.pe_psum = w[i+1];
        end
        @(negedge clk);
        check("bp_last_data", bus.psum_data, w[3]);
        check("bp_last_blocked", bus.pe_ready, 1'b0);
        check("bp_last_almost", bus.psum_almost_valid, 1'b0);
        step();
        check("bp_finish", bus.ctrl_finish, 1'b1);
        check("bp_valid_clr", bus.psum_valid, 1'b0);
        @(negedge clk);
        check("bp_idle_pe_ready", bus.pe_ready, 1'b0);
        bus.pe_valid = 1'b0;
        step();

        // ctrl_valid during RUN must not alter the job.
        start_job(8'd1, 16'd0, 1'b0);
        bus.k_num_i    = 8'd0;
        bus.grp_num_i  = 16'd5;
        bus.bit_mode_i = 1'b1;
        bus.ctrl_valid = 1'b1;
        @(negedge clk);
        check("run_ctrl_ready", bus.ctrl_ready, 1'b0);
        step();
        bus.ctrl_valid = 1'b0;
        beat("run_b0", 96'h00FF, 1'b0);
        beat("run_b1", 96'h0001, 1'b1);
        expect_last_word("run_word", 96'h0100);

        // Reset in the middle of a job.
        start_job(8'd2, 16'd0, 1'b0);
        beat("mid_b0", 96'd100, 1'b0);
        bus.pe_valid = 1'b1;
        bus.pe_psum  = 96'd200;
        #2;
        rst_n = 1'b0;
        #2;
        check("mid_rst_ctrl_ready", bus.ctrl_ready, 1'b1);
        check("mid_rst_valid", bus.psum_valid, 1'b0);
        check("mid_rst_data", bus.psum_data, 96'h0);
        check("mid_rst_pe_ready", bus.pe_ready, 1'b0);
        check("mid_rst_almost", bus.psum_almost_valid, 1'b0);
        check("mid_rst_finish", bus.ctrl_finish, 1'b0);
        bus.pe_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start_job(8'd1, 16'd0, 1'b0);
        beat("post_b0", 96'd5, 1'b0);
        beat("post_b1", 96'd7, 1'b1);
        expect_last_word("post_word", 96'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
